inst_fetch_queue: RTL and testbench

- Instruction fetch front end of the RV32I core; sits directly upstream of decode and immediate extension.
- Generates sequential word fetch addresses to the instruction SRAM and tracks in-flight requests.
- Buffers returned instructions with their PCs in a small FIFO and hands `{pc, instr}` to decode over a valid/ready handshake.
- Branch/jump redirects flush the queue and discard stale in-flight responses.

---
 rtl/inst_fetch_queue_if.sv | 36 +++
 rtl/inst_fetch_queue.sv | 114 +++++++++++
 tb/tb_inst_fetch_queue.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_fetch_queue_if.sv
// Fetch-queue bus bundle: instruction SRAM request/response, execute redirect, decode handoff.
// No storage of its own; all timing is defined by the modules on either side.
// Backpressure is carried by imem_req_ready and inst_ready; responses cannot be stalled.
interface inst_fetch_queue_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_pc;
  logic [31:0] inst_data;

  // master: the fetch queue itself
  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready,
    input  imem_resp_valid, imem_resp_data,
    input  redirect_valid, redirect_pc,
    output inst_valid, inst_pc, inst_data,
    input  inst_ready
  );

  // slave: SRAM, execute and decode seen as one environment
  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready,
    output imem_resp_valid, imem_resp_data,
    output redirect_valid, redirect_pc,
    input  inst_valid, inst_pc, inst_data,
    output inst_ready
  );
endinterface

// File: rtl/inst_fetch_queue.sv
// RV32I fetch front end: sequential word fetch, in-flight tracking, {pc, instr} FIFO to decode.
// Latency: response sampled at edge M gives inst_valid from cycle M+1 (registered FIFO, no bypass).
// Backpressure: requests stop while queued + outstanding reaches DEPTH; redirects flush and drop stale responses.
module inst_fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic               clk,
  input  logic               rst,
  inst_fetch_queue_if.master bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef logic [CW-1:0] cnt_t;
  typedef logic [CW:0]   sum_t;

  localparam sum_t DEPTH_S = sum_t'(DEPTH);

  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_pc_tag;
  logic [63:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  cnt_t          r_count;
  cnt_t          r_outstanding;
  cnt_t          r_drop;
  logic          r_running;

  logic          w_redirect;
  logic          w_resp;
  logic [31:0]   w_redirect_pc;
  sum_t          w_used;
  logic          w_req_valid;
  logic          w_req_fire;
  logic          w_push;
  logic          w_pop;
  logic          w_inst_valid;
  logic [63:0]   w_head;

  assign w_redirect    = bus.redirect_valid;
  assign w_resp        = bus.imem_resp_valid;
  assign w_redirect_pc = bus.redirect_pc & ~32'h0000_0003;

  // Slots already committed: entries waiting for decode plus responses still owed by the SRAM.
  assign w_used      = sum_t'(r_count) + sum_t'(r_outstanding);
  assign w_req_valid = r_running & ~w_redirect & (w_used < DEPTH_S);
  assign w_req_fire  = w_req_valid & bus.imem_req_ready;

  // A response is kept only if it belongs to the current fetch stream.
  assign w_push       = w_resp & ~w_redirect & (r_drop == '0);
  assign w_inst_valid = (r_count != '0);
  assign w_pop        = w_inst_valid & bus.inst_ready & ~w_redirect;
  assign w_head       = r_mem[r_rd_ptr];

  assign bus.imem_req_valid = w_req_valid;
  assign bus.imem_req_addr  = r_fetch_pc;
  assign bus.inst_valid     = w_inst_valid;
  // Head fields read as zero when empty so the decode-side bus is quiet out of reset.
  assign bus.inst_pc        = w_inst_valid ? w_head[63:32] : 32'h0;
  assign bus.inst_data      = w_inst_valid ? w_head[31:0]  : 32'h0;

  // Fetch/response PCs, occupancy counters and the start-up flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fetch_pc    <= RESET_PC;
      r_pc_tag      <= RESET_PC;
      r_count       <= '0;
      r_outstanding <= '0;
      r_drop        <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_running     <= 1'b0;
    end else begin
      r_running     <= 1'b1;
      r_outstanding <= r_outstanding + cnt_t'(w_req_fire) - cnt_t'(w_resp);

      if (w_redirect) begin
        r_fetch_pc <= w_redirect_pc;
        r_pc_tag   <= w_redirect_pc;
        r_count    <= '0;
        r_wr_ptr   <= '0;
        r_rd_ptr   <= '0;
        // Every response still owed is stale now, including ones already marked
        // stale by an earlier redirect; the one arriving this cycle is dropped here.
        r_drop     <= r_outstanding - cnt_t'(w_resp);
      end else begin
        if (w_req_fire) begin
          r_fetch_pc <= r_fetch_pc + 32'd4;
        end
        if (w_push) begin
          r_pc_tag <= r_pc_tag + 32'd4;
          r_wr_ptr <= r_wr_ptr + 1'b1;
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + 1'b1;
        end
        if (w_resp && (r_drop != '0)) begin
          r_drop <= r_drop - 1'b1;
        end
        r_count <= r_count + cnt_t'(w_push) - cnt_t'(w_pop);
      end
    end
  end

  // FIFO storage; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {r_pc_tag, bus.imem_resp_data};
    end
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
module tb_inst_fetch_queue;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  inst_fetch_queue_if bus();

  inst_fetch_queue #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference model: a list of requests the SRAM still owes (each marked stale
  // once a redirect passes it) and a list of instructions waiting for decode.
  typedef struct { logic [31:0] addr; bit stale; int due; } infl_t;
  typedef struct { logic [31:0] pc; logic [31:0] data; } ent_t;

  infl_t       m_infl[$];
  ent_t        m_fifo[$];
  logic [31:0] m_fetch_pc;
  bit          m_running;
  int          cyc = 0;
  int          lat_lo = 1;
  int          lat_hi = 1;

  int checks = 0;
  int errors = 0;

  bit          s_rv, s_iv;
  logic [31:0] s_addr, s_ipc, s_idat;

  typedef struct {
    bit rr; bit ir; bit rd; logic [31:0] rpc;
    bit e_rv; logic [31:0] e_addr; bit e_iv; logic [31:0] e_ipc;
  } vec_t;
  vec_t vecs[18];

  function automatic logic [31:0] sram_data(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive_idle();
    bus.imem_req_ready  = 1'b0;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = 32'h0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_pc     = 32'h0;
    bus.inst_ready      = 1'b0;
  endtask

  task automatic model_clear();
    m_infl.delete();
    m_fifo.delete();
    m_fetch_pc = RESET_PC;
    m_running  = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    drive_idle();
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_valid",  bus.imem_req_valid, 32'h0);
    chk("rst_inst_valid", bus.inst_valid,     32'h0);
    chk("rst_inst_pc",    bus.inst_pc,        32'h0);
    chk("rst_inst_data",  bus.inst_data,      32'h0);
    chk("rst_req_addr",   bus.imem_req_addr,  RESET_PC);
    rst = 1'b1;
  endtask

  // One clock cycle, entered and left at posedge+1.
  task automatic step(input bit req_rdy, input bit inst_rdy, input bit redir,
                      input logic [31:0] rpc);
    bit          exp_rv, fire, pop, resp;
    logic [31:0] rdata;
    infl_t       e;
    ent_t        n;

    s_addr = bus.imem_req_addr;
    s_iv   = bus.inst_valid;
    s_ipc  = bus.inst_pc;
    s_idat = bus.inst_data;
    chk("req_addr", s_addr, m_fetch_pc);
    chk("inst_valid", s_iv, m_fifo.size() > 0);
    if (m_fifo.size() > 0) begin
      chk("inst_pc",   s_ipc,  m_fifo[0].pc);
      chk("inst_data", s_idat, m_fifo[0].data);
    end

    resp = 1'b0;
    if (m_infl.size() > 0) begin
      if (m_infl[0].due <= cyc) resp = 1'b1;
    end
    rdata = resp ? sram_data(m_infl[0].addr) : $urandom();
    bus.imem_req_ready  = req_rdy;
    bus.inst_ready      = inst_rdy;
    bus.redirect_valid  = redir;
    bus.redirect_pc     = rpc;
    bus.imem_resp_valid = resp;
    bus.imem_resp_data  = rdata;
    #1;
    exp_rv = m_running && !redir && ((m_fifo.size() + m_infl.size()) < DEPTH);
    s_rv   = bus.imem_req_valid;
    chk("req_valid", s_rv, exp_rv);
    fire = exp_rv && req_rdy;
    pop  = (m_fifo.size() > 0) && inst_rdy;

    @(posedge clk);
    cyc++;
    if (resp) begin
      e = m_infl.pop_front();
      if (!e.stale && !redir) begin
        n.pc = e.addr; n.data = rdata;
        m_fifo.push_back(n);
      end
    end
    if (redir) begin
      m_fifo.delete();
      foreach (m_infl[i]) m_infl[i].stale = 1'b1;
      m_fetch_pc = {rpc[31:2], 2'b00};
    end else begin
      if (pop) void'(m_fifo.pop_front());
      if (fire) begin
        e.addr  = m_fetch_pc;
        e.stale = 1'b0;
        e.due   = cyc + $urandom_range(lat_hi, lat_lo) - 1;
        m_infl.push_back(e);
        m_fetch_pc = m_fetch_pc + 32'd4;
      end
    end
    m_running = 1'b1;
    #1;
  endtask

  initial begin
    int fires;
    bit seen;

    // Reset, first fetch, 1-cycle SRAM, redirects with simultaneous response/pop, misalignment, wrap.
    vecs[0]  = '{1, 1, 0, 32'h0,         0, 32'h0000_0000, 0, 32'h0};
    vecs[1]  = '{1, 1, 0, 32'h0,         1, 32'h0000_0000, 0, 32'h0};
    vecs[2]  = '{1, 1, 0, 32'h0,         1, 32'h0000_0004, 0, 32'h0};
    vecs[3]  = '{1, 1, 0, 32'h0,         1, 32'h0000_0008, 1, 32'h0000_0000};
    vecs[4]  = '{1, 1, 0, 32'h0,         1, 32'h0000_000C, 1, 32'h0000_0004};
    vecs[5]  = '{1, 1, 1, 32'h40,        0, 32'h0000_0010, 1, 32'h0000_0008};
    vecs[6]  = '{1, 1, 0, 32'h0,         1, 32'h0000_0040, 0, 32'h0};
    vecs[7]  = '{1, 1, 0, 32'h0,         1, 32'h0000_0044, 0, 32'h0};
    vecs[8]  = '{1, 1, 0, 32'h0,         1, 32'h0000_0048, 1, 32'h0000_0040};
    vecs[9]  = '{1, 1, 1, 32'h203,       0, 32'h0000_004C, 1, 32'h0000_0044};
    vecs[10] = '{1, 1, 0, 32'h0,         1, 32'h0000_0200, 0, 32'h0};
    vecs[11] = '{1, 1, 0, 32'h0,         1, 32'h0000_0204, 0, 32'h0};
    vecs[12] = '{1, 1, 0, 32'h0,         1, 32'h0000_0208, 1, 32'h0000_0200};
    vecs[13] = '{1, 1, 1, 32'hFFFF_FFFC, 0, 32'h0000_020C, 1, 32'h0000_0204};
    vecs[14] = '{1, 1, 0, 32'h0,         1, 32'hFFFF_FFFC, 0, 32'h0};
    vecs[15] = '{1, 1, 0, 32'h0,         1, 32'h0000_0000, 0, 32'h0};
    vecs[16] = '{1, 1, 0, 32'h0,         1, 32'h0000_0004, 1, 32'hFFFF_FFFC};
    vecs[17] = '{1, 1, 0, 32'h0,         1, 32'h0000_0008, 1, 32'h0000_0000};

    drive_idle();
    #1;
    do_reset();

    lat_lo = 1; lat_hi = 1;
    for (int i = 0; i < 18; i++) begin
      step(vecs[i].rr, vecs[i].ir, vecs[i].rd, vecs[i].rpc);
      chk($sformatf("vec%0d_req_valid", i),  s_rv,   vecs[i].e_rv);
      chk($sformatf("vec%0d_req_addr", i),   s_addr, vecs[i].e_addr);
      chk($sformatf("vec%0d_inst_valid", i), s_iv,   vecs[i].e_iv);
      if (vecs[i].e_iv) chk($sformatf("vec%0d_inst_pc", i), s_ipc, vecs[i].e_ipc);
    end

    // Full queue: four requests, then stall until decode pops.
    do_reset();
    fires = 0;
    for (int i = 0; i < 10; i++) begin
      step(1, 0, 0, 32'h0);
      if (s_rv) fires++;
    end
    chk("full_fire_count", fires, 4);
    chk("full_req_valid", s_rv, 0);
    step(1, 1, 0, 32'h0);
    chk("full_first_pop_pc", s_ipc, 32'h0);
    chk("full_pop_cycle_req_valid", s_rv, 0);
    step(1, 1, 0, 32'h0);
    chk("full_refill_req_valid", s_rv, 1);
    chk("full_refill_addr", s_addr, 32'h10);
    chk("full_second_pc", s_ipc, 32'h4);

    // Redirect with two responses in flight on a 3-cycle SRAM.
    do_reset();
    lat_lo = 3; lat_hi = 3;
    repeat (3) step(1, 1, 0, 32'h0);
    chk("inflight_before_redirect", m_infl.size(), 2);
    step(1, 1, 1, 32'h100);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step(1, 1, 0, 32'h0);
      if (s_iv) begin
        seen = 1'b1;
        chk("redir_first_pc",   s_ipc,  32'h100);
        chk("redir_first_data", s_idat, sram_data(32'h100));
      end
    end
    if (!seen) chk("redir_first_valid_timeout", 0, 1);

    // Randomised traffic with variable SRAM latency and frequent redirects.
    do_reset();
    lat_lo = 1; lat_hi = 4;
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] rpc;
      rpc = $urandom();
      if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 15) == 0, rpc);
    end

    // Asynchronous reset with the FIFO partly filled.
    do_reset();
    lat_lo = 1; lat_hi = 1;
    repeat (4) step(1, 0, 0, 32'h0);
    chk("midrst_fifo_nonempty", bus.inst_valid, 1);
    #2;
    rst = 1'b0;
    bus.imem_resp_valid = 1'b0;
    bus.redirect_valid  = 1'b0;
    #1;
    chk("midrst_inst_valid_async", bus.inst_valid,     0);
    chk("midrst_req_valid_async",  bus.imem_req_valid, 0);
    do_reset();
    step(1, 1, 0, 32'h0);
    step(1, 1, 0, 32'h0);
    chk("midrst_restart_req_valid", s_rv,   1);
    chk("midrst_restart_addr",      s_addr, RESET_PC);
    repeat (4) step(1, 1, 0, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
